// File: rtl/synch_pkg.sv
// synch_pkg: shared state encoding, comma patterns and 10b code-group checks for synch_multi.
package synch_pkg;
  typedef enum logic [1:0] {LOSS_OF_SYNC, COMMA_DETECT, ACQUIRE_SYNC, SYNC_ACQUIRED} state_t;
  localparam logic [6:0] COMMA_P = 7'b0011111;
  localparam logic [6:0] COMMA_M = 7'b1100000;
  function automatic logic [3:0] ones(input logic [9:0] cg);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) n += {3'd0, cg[i]};
    return n;
  endfunction
  function automatic logic is_comma(input logic [9:0] cg);
    return cg[9:3] == COMMA_P || cg[9:3] == COMMA_M;
  endfunction
  // rd = 1 means running disparity positive
  function automatic logic cg_valid(input logic [9:0] cg, input logic rd);
    logic [3:0] n;
    logic run;
    n = ones(cg);
    run = 1'b0;
    for (int i = 0; i < 5; i++) run |= cg[i +: 6] == 6'h3f || cg[i +: 6] == 6'h00;
    return n >= 4'd4 && n <= 4'd6 && !(n == 4'd6 && rd) && !(n == 4'd4 && !rd) && !run;
  endfunction
endpackage

// File: rtl/synch_lane.sv
// synch_lane: one-lane code-group synchronisation FSM with loss level and good-group counting.
// Optional SYNCH_LOS_CNT_EN adds a saturating count of sync losses.
module synch_lane
  import synch_pkg::*;
#(
  parameter int COMMA_CNT    = 3,
  parameter int LOSS_LIMIT   = 4,
  parameter int GOOD_CGS_MAX = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       force_los,
  input  logic [9:0] pudi,
`ifdef SYNCH_LOS_CNT_EN
  input  logic       los_clr,
  output logic [7:0] los_cnt,
`endif
  output logic       code_sync,
  output logic       rx_even,
  output logic [2:0] good_cgs,
  output logic       sync_next
);
  state_t state, ns;
  logic [2:0] cnt, lvl, n_cnt, n_lvl, n_good;
  logic rd, n_even, comma, valid, bad;
  logic [3:0] n1;
  always_comb begin
    comma = is_comma(pudi);
    valid = cg_valid(pudi, rd);
    bad = !valid || (comma && rx_even);
    n1 = ones(pudi);
    ns = state;
    n_even = !rx_even;
    n_cnt = cnt;
    n_lvl = lvl;
    n_good = good_cgs;
    case (state)
      LOSS_OF_SYNC:
        if (comma) begin
          ns = COMMA_DETECT;
          n_even = 1'b1;
          n_cnt = 3'd1;
        end
      COMMA_DETECT: begin
        n_even = 1'b0;
        ns = (valid && !comma) ? ACQUIRE_SYNC : LOSS_OF_SYNC;
      end
      ACQUIRE_SYNC:
        if (bad) ns = LOSS_OF_SYNC;
        else if (comma) begin
          n_cnt = cnt + 3'd1;
          ns = (n_cnt == 3'(COMMA_CNT)) ? SYNC_ACQUIRED : COMMA_DETECT;
          n_lvl = 3'd0;
          n_good = 3'd0;
        end
      SYNC_ACQUIRED: begin
        n_even = comma || !rx_even;
        if (bad) begin
          n_lvl = lvl + 3'd1;
          n_good = 3'd0;
          if (n_lvl == 3'(LOSS_LIMIT)) ns = LOSS_OF_SYNC;
        end else if (lvl != 3'd0) begin
          n_good = good_cgs + 3'd1;
          if (n_good == 3'(GOOD_CGS_MAX)) begin
            n_lvl = lvl - 3'd1;
            n_good = 3'd0;
          end
        end
      end
    endcase
    if (force_los) begin
      ns = LOSS_OF_SYNC;
      n_even = !rx_even;
    end
    // every path into loss of sync forgets comma count and loss level
    if (ns == LOSS_OF_SYNC) begin
      n_cnt = 3'd0;
      n_lvl = 3'd0;
      n_good = 3'd0;
    end
    sync_next = ns == SYNC_ACQUIRED;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOSS_OF_SYNC;
      rx_even <= 1'b0;
      code_sync <= 1'b0;
      good_cgs <= 3'd0;
      cnt <= 3'd0;
      lvl <= 3'd0;
      rd <= 1'b0;
    end else begin
      state <= ns;
      rx_even <= n_even;
      code_sync <= sync_next;
      good_cgs <= n_good;
      cnt <= n_cnt;
      lvl <= n_lvl;
      rd <= rd ^ (n1 == 4'd4 || n1 == 4'd6);
    end
  end
`ifdef SYNCH_LOS_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || los_clr) los_cnt <= 8'd0;
    else if (state == SYNC_ACQUIRED && ns == LOSS_OF_SYNC && los_cnt != 8'hff) los_cnt <= los_cnt + 8'd1;
  end
`endif
endmodule

// File: rtl/synch_multi.sv
// synch_multi: LANES independent 10b code-group synchronisers with registered aggregate sync.
// Optional SYNCH_LOS_CNT_EN adds LOS_CLR/LOS_CNT per-lane sync-loss counters.
module synch_multi #(
  parameter int LANES        = 1,
  parameter int COMMA_CNT    = 3,
  parameter int LOSS_LIMIT   = 4,
  parameter int GOOD_CGS_MAX = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  POWER,
  input  logic [LANES-1:0]      SIGNAL_CHANGE,
  input  logic [LANES-1:0]      SIGNAL_DETECT,
  input  logic                  MR_LOOPBACK,
  input  logic [10*LANES-1:0]   PUDI,
`ifdef SYNCH_LOS_CNT_EN
  input  logic                  LOS_CLR,
  output logic [8*LANES-1:0]    LOS_CNT,
`endif
  output logic [LANES-1:0]      CODE_SYNC,
  output logic [LANES-1:0]      RX_EVEN,
  output logic [10*LANES-1:0]   SUDI,
  output logic [3*LANES-1:0]    GOOD_CGS,
  output logic                  ALL_SYNC
);
  logic [LANES-1:0] nxt;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    synch_lane #(
      .COMMA_CNT(COMMA_CNT),
      .LOSS_LIMIT(LOSS_LIMIT),
      .GOOD_CGS_MAX(GOOD_CGS_MAX)
    ) u_lane (
      .clk(CLK),
      .rst_n(RESET),
      .force_los(!POWER || SIGNAL_CHANGE[i] || (!SIGNAL_DETECT[i] && !MR_LOOPBACK)),
      .pudi(PUDI[10*i +: 10]),
`ifdef SYNCH_LOS_CNT_EN
      .los_clr(LOS_CLR),
      .los_cnt(LOS_CNT[8*i +: 8]),
`endif
      .code_sync(CODE_SYNC[i]),
      .rx_even(RX_EVEN[i]),
      .good_cgs(GOOD_CGS[3*i +: 3]),
      .sync_next(nxt[i])
    );
  end
  always_ff @(posedge CLK) begin
    SUDI <= RESET ? PUDI : '0;
    ALL_SYNC <= RESET && (&nxt);
  end
endmodule

// File: tb/tb_synch_multi.sv
// tb_synch_multi: directed scoreboard bench for a 4-lane synch_multi.
// K28.5 is sent in the polarity matching running disparity, as a disparity-correct link does.
module tb_synch_multi;
  localparam logic [9:0] KN = 10'b0011111010;
  localparam logic [9:0] KP = 10'b1100000101;
  localparam logic [9:0] DD = 10'b1010010110;
  localparam logic [9:0] ZZ = 10'b0000000000;
  localparam logic [11:0] G1 = {4{3'd1}};
  localparam logic [11:0] G2 = {4{3'd2}};

  typedef struct packed {
    logic [3:0]  sync;
    logic [3:0]  even;
    logic [11:0] good;
    logic [39:0] sudi;
  } exp_t;

  logic clk = 1'b0;
  logic reset, power, loopback;
  logic [3:0] sc, sd;
  logic [39:0] pudi, sudi;
  logic [3:0] code_sync, rx_even;
  logic [11:0] good;
  logic all_sync;
`ifdef SYNCH_LOS_CNT_EN
  logic los_clr = 1'b0;
  logic [31:0] los_cnt;
  logic brd;
`endif
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int stepn = 0;

  always #5 clk = ~clk;

  synch_multi #(.LANES(4)) dut (
    .CLK(clk),
    .RESET(reset),
    .POWER(power),
    .SIGNAL_CHANGE(sc),
    .SIGNAL_DETECT(sd),
    .MR_LOOPBACK(loopback),
    .PUDI(pudi),
`ifdef SYNCH_LOS_CNT_EN
    .LOS_CLR(los_clr),
    .LOS_CNT(los_cnt),
`endif
    .CODE_SYNC(code_sync),
    .RX_EVEN(rx_even),
    .SUDI(sudi),
    .GOOD_CGS(good),
    .ALL_SYNC(all_sync)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL step %0d %s: observed %0h expected %0h", stepn, tag, obs, exp);
    end
  endtask

  task automatic step(input logic [9:0] p, input logic [3:0] es, input logic [3:0] ee, input logic [11:0] eg);
    exp_t e;
    stepn++;
    pudi = {4{p}};
    q.push_back('{sync: es, even: ee, good: eg, sudi: reset ? {4{p}} : 40'd0});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("code_sync", 64'(code_sync), 64'(e.sync));
    chk("rx_even", 64'(rx_even), 64'(e.even));
    chk("good_cgs", 64'(good), 64'(e.good));
    chk("sudi", 64'(sudi), 64'(e.sudi));
    chk("all_sync", 64'(all_sync), 64'(&e.sync));
  endtask

`ifdef SYNCH_LOS_CNT_EN
  task automatic send(input logic [9:0] p);
    pudi = {4{p}};
    @(posedge clk);
    #1;
  endtask
  task automatic send_k;
    send(brd ? KP : KN);
    brd = ~brd;
  endtask
`endif

  initial begin
    reset = 1'b0;
    power = 1'b1;
    loopback = 1'b0;
    sc = 4'h0;
    sd = 4'hf;
    pudi = '0;
    @(negedge clk);
    step(DD, 4'h0, 4'h0, 12'h0);
    step(KN, 4'h0, 4'h0, 12'h0);
    reset = 1'b1;
    // acquisition: comma count 1,2,3
    step(DD, 4'h0, 4'hf, 12'h0);
    step(KN, 4'h0, 4'hf, 12'h0);
    step(DD, 4'h0, 4'h0, 12'h0);
    step(KP, 4'h0, 4'hf, 12'h0);
    step(DD, 4'h0, 4'h0, 12'h0);
    step(KN, 4'hf, 4'hf, 12'h0);
    step(DD, 4'hf, 4'h0, 12'h0);
    step(KP, 4'hf, 4'hf, 12'h0);
    step(DD, 4'hf, 4'h0, 12'h0);
    // four consecutive invalid groups drop sync
    step(ZZ, 4'hf, 4'hf, 12'h0);
    step(ZZ, 4'hf, 4'h0, 12'h0);
    step(ZZ, 4'hf, 4'hf, 12'h0);
    step(ZZ, 4'h0, 4'h0, 12'h0);
    step(KN, 4'h0, 4'hf, 12'h0);
    step(DD, 4'h0, 4'h0, 12'h0);
    step(KP, 4'h0, 4'hf, 12'h0);
    step(DD, 4'h0, 4'h0, 12'h0);
    step(KN, 4'hf, 4'hf, 12'h0);
    step(DD, 4'hf, 4'h0, 12'h0);
    // 3 bad, 3 good (loss level steps down), 1 bad: still synced
    step(ZZ, 4'hf, 4'hf, 12'h0);
    step(ZZ, 4'hf, 4'h0, 12'h0);
    step(ZZ, 4'hf, 4'hf, 12'h0);
    step(DD, 4'hf, 4'h0, G1);
    step(DD, 4'hf, 4'hf, G2);
    step(DD, 4'hf, 4'h0, 12'h0);
    step(ZZ, 4'hf, 4'hf, 12'h0);
    step(DD, 4'hf, 4'h0, G1);
    // lane 2 resync pulse
    sc = 4'b0100;
    step(KP, 4'b1011, 4'hf, {3'd2, 3'd0, 3'd2, 3'd2});
    sc = 4'h0;
    power = 1'b0;
    step(DD, 4'h0, 4'h0, 12'h0);
    power = 1'b1;
    // reset in the middle of acquisition
    step(KN, 4'h0, 4'hf, 12'h0);
    step(DD, 4'h0, 4'h0, 12'h0);
    step(KP, 4'h0, 4'hf, 12'h0);
    step(DD, 4'h0, 4'h0, 12'h0);
    reset = 1'b0;
    step(KN, 4'h0, 4'h0, 12'h0);
    reset = 1'b1;
    step(DD, 4'h0, 4'hf, 12'h0);
    step(KN, 4'h0, 4'hf, 12'h0);
    step(DD, 4'h0, 4'h0, 12'h0);
    step(KP, 4'h0, 4'hf, 12'h0);
    step(DD, 4'h0, 4'h0, 12'h0);
    step(KN, 4'hf, 4'hf, 12'h0);
    // comma on odd position during acquisition
    power = 1'b0;
    step(DD, 4'h0, 4'h0, 12'h0);
    power = 1'b1;
    step(KP, 4'h0, 4'hf, 12'h0);
    step(DD, 4'h0, 4'h0, 12'h0);
    step(DD, 4'h0, 4'hf, 12'h0);
    step(KN, 4'h0, 4'h0, 12'h0);
    step(DD, 4'h0, 4'hf, 12'h0);
    // signal detect with and without loopback
    step(KP, 4'h0, 4'hf, 12'h0);
    step(DD, 4'h0, 4'h0, 12'h0);
    step(KN, 4'h0, 4'hf, 12'h0);
    step(DD, 4'h0, 4'h0, 12'h0);
    step(KP, 4'hf, 4'hf, 12'h0);
    sd = 4'b1110;
    loopback = 1'b1;
    step(DD, 4'hf, 4'h0, 12'h0);
    loopback = 1'b0;
    step(DD, 4'b1110, 4'hf, 12'h0);
    sd = 4'hf;
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard: observed %0d leftover expected 0", q.size());
    end
`ifdef SYNCH_LOS_CNT_EN
    brd = 1'b0;
    power = 1'b0;
    send(DD);
    power = 1'b1;
    los_clr = 1'b1;
    send(DD);
    los_clr = 1'b0;
    for (int n = 0; n < 300; n++) begin
      send_k;
      send(DD);
      send_k;
      send(DD);
      send_k;
      power = 1'b0;
      send(DD);
      power = 1'b1;
      if (n == 0) chk("los_cnt_one", 64'(los_cnt), 64'({4{8'd1}}));
    end
    chk("los_cnt_sat", 64'(los_cnt), 64'({4{8'hff}}));
    los_clr = 1'b1;
    send(DD);
    los_clr = 1'b0;
    chk("los_cnt_clr", 64'(los_cnt), 64'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
